// File: rtl/addr_sequencer.sv
// Sequenced memory-address source: latches a selected base address and walks
// an incrementing multi-beat burst out to memory under a valid/ready handshake.
module addr_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int NSRC    = 4,
  parameter int SEL_W   = 2,
  parameter int BURST_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*ADDR_W-1:0]   src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     req,
  input  logic [BURST_W-1:0]       burst_len,
  input  logic                     ready,
  output logic [ADDR_W-1:0]        addr,
  output logic                     addr_valid,
  output logic                     last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  addr_r, addr_s, base_s;
  logic [BURST_W-1:0] count_r, count_s;
  logic               addr_valid_r, busy_r, done_r;
  logic               addr_valid_s, busy_s, done_s;
  logic               load_s, advance_s, count_zero_s;

  assign count_zero_s = (count_r == {BURST_W{1'b0}});
  assign load_s       = req && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign advance_s    = (state_r == ST_BURST) && ready && !count_zero_s;

  // Source mux: codes with no matching source fall back to Rdest (source 1).
  always_comb begin
    base_s = src_bus[ADDR_W +: ADDR_W];
    for (int k = 0; k < NSRC; k++) begin
      base_s = (sel == SEL_W'(k)) ? src_bus[k*ADDR_W +: ADDR_W] : base_s;
    end
  end

  // Next-state logic; a request in DONE chains straight into the next burst.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) state_s = ST_BURST;
        else     state_s = ST_IDLE;
      end
      ST_BURST: begin
        if (ready && count_zero_s) state_s = ST_DONE;
        else                       state_s = ST_BURST;
      end
      ST_DONE: begin
        if (req) state_s = ST_BURST;
        else     state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Address/count update: load on acceptance, step on each accepted non-final beat.
  always_comb begin
    addr_s  = addr_r;
    count_s = count_r;
    if (load_s) begin
      addr_s  = base_s;
      count_s = burst_len;
    end else if (advance_s) begin
      addr_s  = addr_r + ADDR_W'(1);
      count_s = count_r - BURST_W'(1);
    end else begin
      addr_s  = addr_r;
      count_s = count_r;
    end
  end

  // Output decode from the upcoming state so the flags come straight from flops.
  always_comb begin
    addr_valid_s = (state_s == ST_BURST);
    busy_s       = (state_s == ST_BURST);
    done_s       = (state_s == ST_DONE);
  end

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      count_r      <= {BURST_W{1'b0}};
      addr_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      count_r      <= count_s;
      addr_valid_r <= addr_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign addr       = addr_r;
  assign addr_valid = addr_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign last       = (state_r == ST_BURST) && count_zero_s;

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: stimulus pushes expected beats/done
// pulses, a negedge monitor pops and compares them as the DUT produces them.
module tb_addr_sequencer;

  localparam int ADDR_W  = 10;
  localparam int NSRC    = 4;
  localparam int SEL_W   = 3;
  localparam int BURST_W = 3;

  typedef struct {
    bit              is_done;
    logic [ADDR_W-1:0] a;
    bit              lst;
  } exp_t;

  logic                   clk;
  logic                   reset;
  logic [NSRC*ADDR_W-1:0] src_bus;
  logic [SEL_W-1:0]       sel;
  logic                   req;
  logic [BURST_W-1:0]     burst_len;
  logic                   ready;
  logic [ADDR_W-1:0]      addr;
  logic                   addr_valid, last, busy, done;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  addr_sequencer #(.ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W), .BURST_W(BURST_W)) u_dut (
    .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel), .req(req),
    .burst_len(burst_len), .ready(ready), .addr(addr), .addr_valid(addr_valid),
    .last(last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [ADDR_W-1:0] a, input bit lst);
    exp_t e;
    e.is_done = 1'b0; e.a = a; e.lst = lst;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.a = '0; e.lst = 1'b0;
    q.push_back(e);
  endtask

  task automatic set_src(input int k, input logic [ADDR_W-1:0] v);
    src_bus[k*ADDR_W +: ADDR_W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
    chk({name, "_valid"}, {31'd0, addr_valid}, 32'd0);
  endtask

  // Monitor: every accepted beat and every done cycle must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (addr_valid === 1'b1 && ready === 1'b1) begin
      chk("beat_expected", {31'd0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("beat_kind", {31'd0, e.is_done}, 32'd0);
        chk("beat_addr", {22'd0, addr}, {22'd0, e.a});
        chk("beat_last", {31'd0, last}, {31'd0, e.lst});
      end
    end
    if (done === 1'b1) begin
      chk("done_expected", {31'd0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("done_kind", {31'd0, e.is_done}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rpat;
    bit seen;

    // Reset with random inputs
    reset = 1'b1; ready = 1'b0;
    src_bus = {$urandom, $urandom};
    sel = SEL_W'($urandom); req = 1'($urandom); burst_len = BURST_W'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr",  {22'd0, addr}, 32'd0);
    chk("rst_valid", {31'd0, addr_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_last",  {31'd0, last}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0; src_bus = '0;

    // PC single beat
    set_src(0, 10'h123); sel = 3'd0; burst_len = 3'd0; ready = 1'b1; req = 1'b1;
    push_beat(10'h123, 1'b1); push_done();
    step(); req = 1'b0;
    @(negedge clk);
    chk("pc_busy", {31'd0, busy}, 32'd1);
    wait_idle("pc_idle");

    // Rdest burst with stalls
    step();
    set_src(1, 10'h040); sel = 3'd1; burst_len = 3'd3; ready = 1'b1; req = 1'b1;
    push_beat(10'h040, 1'b0); push_beat(10'h041, 1'b0);
    push_beat(10'h042, 1'b0); push_beat(10'h043, 1'b1); push_done();
    step(); req = 1'b0;
    rpat = 6'b111001;
    for (int i = 0; i < 6; i++) begin
      ready = rpat[i];
      @(negedge clk);
      if (i == 1 || i == 2) begin
        chk("stall_addr",  {22'd0, addr}, 32'h041);
        chk("stall_valid", {31'd0, addr_valid}, 32'd1);
        chk("stall_last",  {31'd0, last}, 32'd0);
      end
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_idle("stall_idle");

    // Wrap, then back-to-back request held through DONE
    step();
    set_src(2, 10'h3FE); sel = 3'd2; burst_len = 3'd3; req = 1'b1;
    push_beat(10'h3FE, 1'b0); push_beat(10'h3FF, 1'b0);
    push_beat(10'h000, 1'b0); push_beat(10'h001, 1'b1); push_done();
    step();
    set_src(2, 10'h000); set_src(3, 10'h100); sel = 3'd3; burst_len = 3'd0;
    push_beat(10'h100, 1'b1); push_done();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {31'd0, addr_valid}, 32'd1);
    chk("b2b_addr",  {22'd0, addr}, 32'h100);
    wait_idle("b2b_idle");

    // Out-of-range select falls back to Rdest; req during BURST is ignored
    step();
    set_src(0, 10'h011); set_src(1, 10'h2A0); set_src(2, 10'h155); set_src(3, 10'h0F0);
    sel = 3'd5; burst_len = 3'd2; req = 1'b1;
    push_beat(10'h2A0, 1'b0); push_beat(10'h2A1, 1'b0); push_beat(10'h2A2, 1'b1); push_done();
    step();
    sel = 3'd0;
    step(); req = 1'b0;
    step(); req = 1'b1;
    step(); req = 1'b0;
    wait_idle("oor_idle");

    // Reset in the middle of an 8-beat burst
    step();
    set_src(0, 10'h200); sel = 3'd0; burst_len = 3'd7; req = 1'b1;
    push_beat(10'h200, 1'b0); push_beat(10'h201, 1'b0);
    step(); req = 1'b0;
    step();
    step(); ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("mid_beat2_addr", {22'd0, addr}, 32'h202);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, addr_valid}, 32'd0);
    chk("mid_rst_addr",  {22'd0, addr}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_done",  {31'd0, done}, 32'd0);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("sb_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
